// File: rtl/hpdcache_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_ctrl_pkg
//   Shared types and constants for the bit-masked SRAM port controller.
//   - ctrl_state_e  : controller FSM state (zero-sweep / normal service)
//   - RSP_BUF_DEPTH : number of read responses that can be held back
//   - RSP_CNT_W     : width of the response buffer occupancy counter
// ---------------------------------------------------------------------------
package hpdcache_sram_ctrl_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

   localparam int unsigned RSP_BUF_DEPTH = 2;
   localparam int unsigned RSP_CNT_W     = $clog2(RSP_BUF_DEPTH + 1);

endpackage

// File: rtl/hpdcache_sram_wmask_ctrl_if.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_wmask_ctrl_if
//   Bundles every non-clock signal of the SRAM port controller:
//   - request stream  : req_valid_i/req_ready_o plus we/addr/wdata/wmask
//   - response stream : rsp_valid_o/rsp_ready_i plus rsp_rdata_o
//   - status          : init_done_o
//   - SRAM macro port : sram_cs_o/we/addr/wdata/wmask, sram_rdata_i
//   Modport slave is the controller's view, master is the surrounding
//   logic's view (requester, response consumer and SRAM macro).
//
//   Handshake rule for both streams: a transfer happens on a rising clock
//   edge where valid and ready are both high; the sender keeps its payload
//   stable while valid is high and ready is low, and ready never depends on
//   valid of the same stream.
// ---------------------------------------------------------------------------
interface hpdcache_sram_wmask_ctrl_if #(
   parameter int unsigned ADDR_SIZE = 0,
   parameter int unsigned DATA_SIZE = 0
);
   localparam int unsigned AW = (ADDR_SIZE > 0) ? ADDR_SIZE : 1;
   localparam int unsigned DW = (DATA_SIZE > 0) ? DATA_SIZE : 1;

   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic [DW-1:0] req_wmask_i;

   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_rdata_o;

   logic          init_done_o;

   logic          sram_cs_o;
   logic          sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_wdata_o;
   logic [DW-1:0] sram_wmask_o;
   logic [DW-1:0] sram_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
      output req_ready_o,
      output rsp_valid_o, rsp_rdata_o,
      input  rsp_ready_i,
      output init_done_o,
      output sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      input  sram_rdata_i
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_rdata_o,
      output rsp_ready_i,
      input  init_done_o,
      input  sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      output sram_rdata_i
   );

endinterface

// File: rtl/hpdcache_sram_rsp_buf.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_rsp_buf
//   Registered FIFO holding read data until the consumer takes it.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset (empties the FIFO)
//     push        : write push_data at the tail this cycle
//     push_data   : data to enqueue
//     pop         : drop the head entry this cycle
//     count       : number of valid entries (0..RSP_BUF_DEPTH)
//     head        : oldest entry; meaningful only while count > 0
//   The caller guarantees no push into a full buffer (credit scheme) and no
//   pop from an empty one.
// ---------------------------------------------------------------------------
module hpdcache_sram_rsp_buf
   import hpdcache_sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [RSP_CNT_W-1:0] count,
   output logic [DATA_SIZE-1:0] head
);

   localparam int unsigned PTR_W = (RSP_BUF_DEPTH > 1) ? $clog2(RSP_BUF_DEPTH) : 1;

   logic [DATA_SIZE-1:0] mem_q [RSP_BUF_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [RSP_CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(RSP_BUF_DEPTH - 1)) begin
         return '0;
      end
      return ptr + 1'b1;
   endfunction

   // Storage is not reset: entries are only observed through count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hpdcache_sram_wmask_ctrl.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_wmask_ctrl
//   Initiator-side controller for a 1RW bit-masked SRAM with 1-cycle read
//   latency. After reset it optionally sweeps every word to zero (INIT),
//   then passes a valid/ready request stream straight to the SRAM (RUN),
//   returning read data through a 2-entry response buffer so the consumer
//   may apply backpressure.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     bus        : request/response streams, init_done and SRAM port
//     dbg_state  : current FSM state, for observation only
// ---------------------------------------------------------------------------
module hpdcache_sram_wmask_ctrl
   import hpdcache_sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_SIZE     = 0,
   parameter int unsigned DATA_SIZE     = 0,
   parameter int unsigned DEPTH         = 2 ** ADDR_SIZE,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   hpdcache_sram_wmask_ctrl_if.slave      bus,
   output ctrl_state_e                    dbg_state
);

   localparam int unsigned AW = (ADDR_SIZE > 0) ? ADDR_SIZE : 1;
   localparam int unsigned DW = (DATA_SIZE > 0) ? DATA_SIZE : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam ctrl_state_e   RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

   ctrl_state_e          state_q, state_d;
   logic [AW-1:0]        init_cnt_q, init_cnt_d;
   logic                 inflight_q, inflight_d;

   logic [RSP_CNT_W-1:0] buf_count;
   logic [DW-1:0]        buf_head;
   logic                 buf_valid;
   logic                 buf_pop;
   logic [2:0]           used;
   logic                 credit_ok;

   logic                 req_ready;
   logic                 sram_cs;
   logic                 sram_we;
   logic [AW-1:0]        sram_addr;
   logic [DW-1:0]        sram_wdata;
   logic [DW-1:0]        sram_wmask;

   // -------------------------------------------------------------------------
   // Response buffer: SRAM data is captured at the end of the cycle that
   // follows an accepted read (inflight), so responses come out registered.
   // -------------------------------------------------------------------------
   hpdcache_sram_rsp_buf #(
      .DATA_SIZE (DW)
   ) u_rsp_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (bus.sram_rdata_i),
      .pop       (buf_pop),
      .count     (buf_count),
      .head      (buf_head)
   );

   assign buf_valid = (buf_count != '0);
   assign buf_pop   = buf_valid & bus.rsp_ready_i;

   // credits = DEPTH - count - inflight + pop; credits > 0 is rewritten as
   // count + inflight < DEPTH + pop to stay in unsigned arithmetic.
   assign used      = 3'(buf_count) + 3'(inflight_q);
   assign credit_ok = used < (3'(RSP_BUF_DEPTH) + 3'(buf_pop));

   // -------------------------------------------------------------------------
   // FSM state, sweep counter and inflight flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         init_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      req_ready  = 1'b0;
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wmask = '0;

      case (state_q)
         ST_INIT: begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = init_cnt_q;
            sram_wdata = '0;
            sram_wmask = '1;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
               state_d    = ST_RUN;
               init_cnt_d = '0;
            end
         end
         ST_RUN: begin
            // Writes never consume a response slot, so they are never held.
            req_ready  = bus.req_we_i | credit_ok;
            sram_cs    = bus.req_valid_i & req_ready;
            sram_we    = bus.req_we_i;
            sram_addr  = bus.req_addr_i;
            sram_wdata = bus.req_wdata_i;
            sram_wmask = bus.req_wmask_i;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase

      // While reset is held nothing may reach the macro.
      if (!rst_n) begin
         req_ready = 1'b0;
         sram_cs   = 1'b0;
      end

      inflight_d = bus.req_valid_i & req_ready & ~bus.req_we_i;
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.req_ready_o  = req_ready;
   assign bus.rsp_valid_o  = buf_valid;
   assign bus.rsp_rdata_o  = buf_head;
   assign bus.init_done_o  = (state_q == ST_RUN);
   assign bus.sram_cs_o    = sram_cs;
   assign bus.sram_we_o    = sram_we;
   assign bus.sram_addr_o  = sram_addr;
   assign bus.sram_wdata_o = sram_wdata;
   assign bus.sram_wmask_o = sram_wmask;
   assign dbg_state        = state_q;

endmodule
